// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg -- byte-lane constant and helpers shared by the register file.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int unsigned BYTE_W = 8;

  // One byte lane: keep the old byte unless this lane is enabled.
  function automatic logic [BYTE_W-1:0] be_merge(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              be
  );
    return be ? new_b : old_b;
  endfunction

  function automatic logic addr_ok(
    input int unsigned addr,
    input int unsigned depth,
    input bit          zero_reg
  );
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ---------------------------------------------------------------------------
// regfile_rd_port -- one combinational read port with range, zero-reg and bypass priority.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned NB      = WIDTH / BYTE_W
) (
  input  logic              rst_n_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WIDTH-1:0]  st_data_i,
  input  logic              st_busy_i,
  input  logic [AW-1:0]     waddr0_i,
  input  logic [WIDTH-1:0]  wdata0_i,
  input  logic [NB-1:0]     wbe0_i,
  input  logic [AW-1:0]     waddr1_i,
  input  logic [WIDTH-1:0]  wdata1_i,
  input  logic [NB-1:0]     wbe1_i,
  input  logic              alloc_valid_i,
  input  logic [AW-1:0]     alloc_reg_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              busy_o
);

  logic             hit0;
  logic             hit1;
  logic [WIDTH-1:0] fwd;

  assign hit0 = BYPASS && (|wbe0_i) && (waddr0_i == addr_i);
  assign hit1 = BYPASS && (|wbe1_i) && (waddr1_i == addr_i);

  // Port 1 is applied last so it wins on overlapping bytes, matching the commit order.
  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign fwd[b*BYTE_W +: BYTE_W] =
      be_merge(be_merge(st_data_i[b*BYTE_W +: BYTE_W], wdata0_i[b*BYTE_W +: BYTE_W],
                        hit0 && wbe0_i[b]),
               wdata1_i[b*BYTE_W +: BYTE_W], hit1 && wbe1_i[b]);
  end

  always_comb begin
    data_o = st_data_i;
    busy_o = st_busy_i;
    if (!rst_n_i || !addr_ok(32'(addr_i), DEPTH, ZERO_REG)) begin
      data_o = '0;
      busy_o = 1'b0;
    end else if (hit0 || hit1) begin
      data_o = fwd;
      busy_o = alloc_valid_i && (alloc_reg_i == addr_i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-port register file with byte enables, bypass and pending scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned NB      = WIDTH / BYTE_W
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_RD*AW-1:0]    RdAddr,
  output logic [NUM_RD*WIDTH-1:0] RdData,
  output logic [NUM_RD-1:0]       RdBusy,
  input  logic [AW-1:0]           WAddr0,
  input  logic [WIDTH-1:0]        WData0,
  input  logic [NB-1:0]           WBe0,
  input  logic [AW-1:0]           WAddr1,
  input  logic [WIDTH-1:0]        WData1,
  input  logic [NB-1:0]           WBe1,
  input  logic                    AllocValid,
  input  logic [AW-1:0]           AllocReg
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  logic w0_ok;
  logic w1_ok;
  logic al_ok;

  assign w0_ok = (|WBe0) && addr_ok(32'(WAddr0), DEPTH, ZERO_REG);
  assign w1_ok = (|WBe1) && addr_ok(32'(WAddr1), DEPTH, ZERO_REG);
  assign al_ok = AllocValid && addr_ok(32'(AllocReg), DEPTH, ZERO_REG);

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    logic h0;
    logic h1;
    logic ha;

    assign h0 = w0_ok && (WAddr0 == AW'(r));
    assign h1 = w1_ok && (WAddr1 == AW'(r));
    assign ha = al_ok && (AllocReg == AW'(r));

    for (genvar b = 0; b < NB; b++) begin : g_byte
      assign regs_d[r][b*BYTE_W +: BYTE_W] =
        be_merge(be_merge(regs_q[r][b*BYTE_W +: BYTE_W], WData0[b*BYTE_W +: BYTE_W],
                          h0 && WBe0[b]),
                 WData1[b*BYTE_W +: BYTE_W], h1 && WBe1[b]);
    end

    // A fresh alloc outranks a completing write: a newer producer now owns the register.
    assign pend_d[r] = ha | (pend_q[r] & ~(h0 | h1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] st_data;
    logic             st_busy;

    assign addr    = RdAddr[k*AW +: AW];
    assign st_data = (32'(addr) < DEPTH) ? regs_q[addr] : '0;
    assign st_busy = (32'(addr) < DEPTH) ? pend_q[addr] : 1'b0;

    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .rst_n_i       (RST_N),
      .addr_i        (addr),
      .st_data_i     (st_data),
      .st_busy_i     (st_busy),
      .waddr0_i      (WAddr0),
      .wdata0_i      (WData0),
      .wbe0_i        (WBe0),
      .waddr1_i      (WAddr1),
      .wdata1_i      (WData1),
      .wbe1_i        (WBe1),
      .alloc_valid_i (AllocValid),
      .alloc_reg_i   (AllocReg),
      .data_o        (RdData[k*WIDTH +: WIDTH]),
      .busy_o        (RdBusy[k])
    );
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle CPU's two-read/one-write register file.
- Generalised in width, depth and read-port count.
- Adds a second write port, per-byte write enables, write-to-read bypass and a per-register pending (scoreboard) bit for multi-cycle producers.
- Sits between decode (read ports, alloc) and writeback (two write ports: ALU result and load/multi-cycle result).

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of architectural registers; need not be a power of 2.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and alloc.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RdAddr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- RdData  out  NUM_RD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH].
- RdBusy  out  NUM_RD  pending bit of the addressed register, after bypass.
- WAddr0  in  AW  write port 0 address.
- WData0  in  WIDTH  write port 0 data.
- WBe0  in  WIDTH/8  write port 0 byte enables; all-zero means no write.
- WAddr1  in  AW  write port 1 address.
- WData1  in  WIDTH  write port 1 data.
- WBe1  in  WIDTH/8  write port 1 byte enables; all-zero means no write.
- AllocValid  in  1  mark register AllocReg pending.
- AllocReg  in  AW  register to mark pending.

Behaviour:
- Reset is asynchronous and active-low (RST_N = 0). It immediately clears all registers and all pending bits. RdData and RdBusy read 0 for every address while RST_N is low. Writes and alloc are ignored while RST_N is low.
- Reads are combinational with zero latency. Per read port, highest priority first:
  - Address >= DEPTH: data 0, busy 0.
  - ZERO_REG = 1 and address 0: data 0, busy 0.
  - BYPASS = 1 and the address matches a write port with a nonzero byte enable: forwarded value.
  - Otherwise: stored value and stored pending bit.
- Forwarded value: the stored word with each enabled byte replaced. Byte b takes WData1 if WBe1[b] is set, else WData0 if WBe0[b] is set and port 0 matches, else the stored byte. RdBusy is 0 when forwarding, unless AllocValid targets the same register in that cycle, in which case RdBusy is 1.
- Writes commit on the rising clock edge, byte-granular. When both ports hit the same register, they merge per byte and port 1 wins on overlapping bytes.
- Writes to address >= DEPTH are ignored. With ZERO_REG = 1, writes to address 0 are ignored.
- Pending bits:
  - Set on the rising edge when AllocValid = 1.
  - Cleared on the rising edge by any write with a nonzero byte enable to that register.
  - Alloc and write to the same register in the same cycle: alloc wins and the bit stays 1, because a newer producer has been allocated.
  - Alloc to register 0 (when ZERO_REG = 1) or to an address >= DEPTH is ignored.
- With BYPASS = 0, reads always return the stored value and stored pending bit. A write becomes visible the cycle after it is issued.
- Deasserting reset mid-operation: the first rising edge after RST_N goes high behaves as a normal cycle.

Decomposition:
- Package regfile_pkg:
  - Byte-lane constant BYTE_W = 8.
  - Function be_merge(old, new, be) for the per-byte merge.
  - Range-check function addr_ok(addr, DEPTH, ZERO_REG).
- Sub-module regfile_rd_port: one instance per read port, generated NUM_RD times. It takes the stored word and pending bit, both write ports and alloc, and produces RdData and RdBusy. It contains all bypass and priority logic.

Test Plan:
- Reset and zero register:
  - Drive RST_N low mid-run after writing reg 5 = 0xDEADBEEF -> reg 5 reads 0 immediately, all RdBusy = 0.
  - Write reg 0 = 0xFFFFFFFF with ZERO_REG = 1 -> reg 0 still reads 0.
- Byte enables: write reg 3 = 0x11223344 with BE 0xF, then 0xAABBCCDD with BE 0x5 -> reg 3 reads 0x11BB33DD.
- Dual-write conflict: same cycle, port 0 writes reg 7 = 0x01020304 with BE 0xF and port 1 writes 0xA0B0C0D0 with BE 0x3 -> reg 7 = 0x0102C0D0 after the edge. Bypass shows the same value during the write cycle.
- Scoreboard:
  - Alloc reg 9 -> RdBusy = 1 on the next cycle.
  - Port 1 writes reg 9 = 0x55 -> in the write cycle, data 0x55 and busy 0 via bypass; busy stays 0 afterwards.
  - Alloc and write reg 9 in the same cycle -> busy remains 1.
- BYPASS = 0 instance: write reg 4 = 0x77 -> the same-cycle read returns the old value, and the next cycle returns 0x77.
- DEPTH = 24, NUM_RD = 3 instance: write to address 30 is ignored and reads of it return 0. All three read ports return independent correct values.
